// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter for the shared integer ALU. It steers the granted
// requester's operands to the ALU and registers the result toward the CDB.
module alu_issue_arbiter #(
    parameter int NUM_RS = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int TAG_W  = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RS-1:0]        req_valid,
    input  logic [NUM_RS*OP_W-1:0]   req_op,
    input  logic [NUM_RS*DATA_W-1:0] req_a,
    input  logic [NUM_RS*DATA_W-1:0] req_b,
    input  logic [NUM_RS*TAG_W-1:0]  req_tag,
    output logic [NUM_RS-1:0]        req_grant,
    output logic [OP_W-1:0]          alu_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     flush,
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [TAG_W-1:0]         cdb_tag
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [OP_W-1:0]   op_arr  [NUM_RS];
    logic [DATA_W-1:0] a_arr   [NUM_RS];
    logic [DATA_W-1:0] b_arr   [NUM_RS];
    logic [TAG_W-1:0]  tag_arr [NUM_RS];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic              can_issue;
    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  grant_idx_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_unpack
            assign op_arr[gi]    = req_op[gi*OP_W +: OP_W];
            assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
            assign tag_arr[gi]   = req_tag[gi*TAG_W +: TAG_W];
            assign req_grant[gi] = grant_found && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // The output register may accept a new result if empty or draining now.
    assign can_issue = !out_valid_q || cdb_ready;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        if (can_issue && !flush && !reset) begin
            for (int k = 0; k < NUM_RS; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_RS;
                if (!grant_found && req_valid[PTR_W'(idx)]) begin
                    grant_found = 1'b1;
                    grant_idx   = PTR_W'(idx);
                end
            end
        end
    end

    assign grant_idx_inc = (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + PTR_W'(1);

    assign alu_op = grant_found ? op_arr[grant_idx] : '0;
    assign alu_a  = grant_found ? a_arr[grant_idx]  : '0;
    assign alu_b  = grant_found ? b_arr[grant_idx]  : '0;

    // Flush outranks both a new grant and a drain; reset is handled in the register.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (grant_found) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
            out_tag_d   = tag_arr[grant_idx];
            rr_ptr_d    = grant_idx_inc;
        end else if (out_valid_q && cdb_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign cdb_valid = out_valid_q;
    assign cdb_data  = out_data_q;
    assign cdb_tag   = out_tag_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_alu_issue_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 5;
    localparam int TW = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*OW-1:0]   req_op;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N*TW-1:0]   req_tag;
    logic [N-1:0]      req_grant;
    logic [OW-1:0]     alu_op;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [DW-1:0]     alu_result;
    logic              flush;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [DW-1:0]     cdb_data;
    logic [TW-1:0]     cdb_tag;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Requester fields kept as arrays, packed onto the flat buses.
    logic [OW-1:0] f_op  [N];
    logic [DW-1:0] f_a   [N];
    logic [DW-1:0] f_b   [N];
    logic [TW-1:0] f_tag [N];

    // Reference model state.
    int          m_ptr;
    bit          m_vld;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    logic [N-1:0]  last_grant;

    alu_issue_arbiter #(.NUM_RS(N), .DATA_W(DW), .OP_W(OW), .TAG_W(TW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .req_grant  (req_grant),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_ready  (cdb_ready),
        .cdb_data   (cdb_data),
        .cdb_tag    (cdb_tag)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            5'd0:    return a & b;
            5'd1:    return a | b;
            5'd2:    return a + b;
            5'd3:    return a - b;
            5'd4:    return a << b[4:0];
            5'd5:    return a >> b[4:0];
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW]  = f_op[i];
            req_a[i*DW +: DW]   = f_a[i];
            req_b[i*DW +: DW]   = f_b[i];
            req_tag[i*TW +: TW] = f_tag[i];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] tag);
        f_op[i] = op; f_a[i] = a; f_b[i] = b; f_tag[i] = tag;
    endtask

    // Entered at a negedge with fields already set; returns at the next negedge.
    task automatic step(input logic rst, input logic fl, input logic rdy, input logic [N-1:0] v);
        int g;
        int best;
        int d;
        logic [N-1:0] exp_grant;
        reset = rst; flush = fl; cdb_ready = rdy; req_valid = v;
        #1;
        // Winner: the valid requester at the shortest forward distance from the pointer.
        g = -1;
        best = N;
        if (!rst && !fl && (!m_vld || rdy)) begin
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (v[i] && d < best) begin
                    best = d;
                    g = i;
                end
            end
        end
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        check_val("grant", 64'(req_grant), 64'(exp_grant));
        check_val("alu_op", 64'(alu_op), (g >= 0) ? 64'(f_op[g]) : 64'd0);
        check_val("alu_a", 64'(alu_a), (g >= 0) ? 64'(f_a[g]) : 64'd0);
        check_val("alu_b", 64'(alu_b), (g >= 0) ? 64'(f_b[g]) : 64'd0);
        check_val("cdb_valid", 64'(cdb_valid), 64'(m_vld));
        check_val("cdb_data", 64'(cdb_data), 64'(m_data));
        check_val("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        last_grant = req_grant;
        $display("cyc %0d rst=%b fl=%b rdy=%b v=%b grant=%b cdb_v=%b data=%h tag=%0d",
                 cyc, rst, fl, rdy, v, req_grant, cdb_valid, cdb_data, cdb_tag);
        @(posedge clock);
        if (rst) begin
            m_ptr = 0; m_vld = 0; m_data = '0; m_tag = '0;
        end else if (fl) begin
            m_vld = 0;
        end else if (g >= 0) begin
            m_vld  = 1;
            m_data = alu_fn(f_op[g], f_a[g], f_b[g]);
            m_tag  = f_tag[g];
            m_ptr  = (g + 1) % N;
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        logic [DW-1:0] held_data;
        logic [TW-1:0] held_tag;
        logic [N-1:0]  v;

        for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, '0);
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b0; req_valid = '0;
        m_ptr = 0; m_vld = 0; m_data = '0; m_tag = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // 1: single AND request
        set_req(0, 5'd0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 6'd5);
        step(0, 0, 1, 4'b0001);
        check_val("t1_grant", 64'(last_grant), 64'(4'b0001));
        check_val("t1_valid", 64'(cdb_valid), 64'd1);
        check_val("t1_data", 64'(cdb_data), 64'h00F0_00FF);
        check_val("t1_tag", 64'(cdb_tag), 64'd5);
        // pointer now 1: a lone request at 0 and 1 must go to 1
        set_req(1, 5'd2, 32'd7, 32'd8, 6'd9);
        step(0, 0, 1, 4'b0011);
        check_val("t1_ptr", 64'(last_grant), 64'(4'b0010));

        // 2: all requesting, rotating grants from a fresh reset
        step(1, 0, 1, 4'b0000);
        for (int i = 0; i < N; i++) set_req(i, 5'(i), 32'h1000 + 32'(i), 32'(i + 1), 6'(10 + i));
        for (int k = 0; k < N; k++) begin
            step(0, 0, 1, 4'b1111);
            check_val("t2_grant", 64'(last_grant), 64'(1) << k);
            check_val("t2_tag", 64'(cdb_tag), 64'(10 + k));
            check_val("t2_valid", 64'(cdb_valid), 64'd1);
        end

        // 3: stall holds the register, grant arrives with cdb_ready
        held_data = cdb_data;
        held_tag  = cdb_tag;
        set_req(2, 5'd3, 32'd100, 32'd1, 6'd33);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 4'b0100);
            check_val("t3_nogrant", 64'(last_grant), 64'd0);
            check_val("t3_data", 64'(cdb_data), 64'(held_data));
            check_val("t3_tag", 64'(cdb_tag), 64'(held_tag));
        end
        step(0, 0, 1, 4'b0100);
        check_val("t3_grant", 64'(last_grant), 64'(4'b0100));
        check_val("t3_valid", 64'(cdb_valid), 64'd1);
        check_val("t3_result", 64'(cdb_data), 64'd99);

        // 4: pointer at 3 wraps
        step(0, 0, 1, 4'b1001);
        check_val("t4_grant3", 64'(last_grant), 64'(4'b1000));
        step(0, 0, 1, 4'b1001);
        check_val("t4_grant0", 64'(last_grant), 64'(4'b0001));

        // 5: flush drops the held result, pointer stays at 1
        step(0, 1, 1, 4'b0010);
        check_val("t5_nogrant", 64'(last_grant), 64'd0);
        check_val("t5_valid", 64'(cdb_valid), 64'd0);
        step(0, 0, 1, 4'b0011);
        check_val("t5_ptr", 64'(last_grant), 64'(4'b0010));

        // 6: reset mid-operation
        step(1, 0, 1, 4'b1111);
        check_val("t6_nogrant", 64'(last_grant), 64'd0);
        check_val("t6_valid", 64'(cdb_valid), 64'd0);
        check_val("t6_data", 64'(cdb_data), 64'd0);
        check_val("t6_tag", 64'(cdb_tag), 64'd0);
        step(0, 0, 1, 4'b1111);
        check_val("t6_first", 64'(last_grant), 64'(4'b0001));

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 5'($urandom_range(0, 7)), $urandom, $urandom, 6'($urandom));
            v = 4'($urandom);
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single integer ALU functional unit (AND/OR/ADD/SUB/shift datapath) among NUM_RS reservation-station requesters.
- Picks one ready instruction per cycle by round-robin and steers its operands and opcode to the combinational ALU.
- Captures the ALU result in a one-entry output register and drives it to the common data bus (CDB) with a valid/ready handshake.
- Sits between the reservation stations and the CDB arbiter in the out-of-order backend.

Parameters:
- NUM_RS, 4, number of requesters; legal range 2–8.
- DATA_W, 32, operand and result width.
- OP_W, 5, ALU opcode width.
- TAG_W, 6, ROB/physical-register tag width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_RS  per-requester instruction-ready flag.
- req_op  input  NUM_RS*OP_W  flattened opcodes; requester i occupies bits [i*OP_W +: OP_W].
- req_a  input  NUM_RS*DATA_W  flattened operand A.
- req_b  input  NUM_RS*DATA_W  flattened operand B.
- req_tag  input  NUM_RS*TAG_W  flattened destination tags.
- req_grant  output  NUM_RS  one-hot grant, combinational, same cycle as the request.
- alu_op  output  OP_W  opcode steered to the ALU.
- alu_a  output  DATA_W  operand A steered to the ALU.
- alu_b  output  DATA_W  operand B steered to the ALU.
- alu_result  input  DATA_W  combinational ALU result for the current alu_* inputs.
- flush  input  1  branch-mispredict squash.
- cdb_valid  output  1  output register holds a result.
- cdb_ready  input  1  CDB accepts the result this cycle.
- cdb_data  output  DATA_W  registered result.
- cdb_tag  output  TAG_W  registered tag.

Behaviour:
- State:
  - rr_ptr: log2(NUM_RS) bits, the highest-priority requester index.
  - Output register: out_valid, out_data, out_tag.
- Reset (synchronous, while reset=1):
  - rr_ptr=0, out_valid=0, out_data=0, out_tag=0.
  - req_grant forced to 0 combinationally.
- can_issue = !out_valid || cdb_ready. The register is free, or it is draining this cycle.
- Arbitration, all combinational:
  - If can_issue and !flush and !reset, search req_valid starting at rr_ptr and wrapping: rr_ptr, rr_ptr+1, …, NUM_RS-1, 0, …, rr_ptr-1.
  - The first asserted requester g gets req_grant[g]=1. At most one grant bit is set per cycle.
- ALU steering:
  - alu_op/alu_a/alu_b = requester g's fields when a grant is given; otherwise all-zero.
- Edge update on a grant:
  - out_data <= alu_result, out_tag <= req_tag[g], out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_RS.
  - Issue-to-cdb_valid latency is 1 cycle.
- Drain:
  - When out_valid && cdb_ready and no new grant, out_valid <= 0. out_data/out_tag hold their last value.
- Simultaneous drain and grant: the register is overwritten with the new result and out_valid stays 1. Back-to-back throughput is 1 result/cycle.
- Stall: out_valid && !cdb_ready means no grant; cdb_data/cdb_tag are held stable until accepted.
- No request: rr_ptr unchanged, no grant.
- Flush:
  - Next edge sets out_valid <= 0, dropping the held result even if cdb_ready=1 that cycle.
  - No grant in the flush cycle; rr_ptr unchanged.
  - Flush wins over any simultaneous grant or drain.
- Reset mid-operation discards any held result; reset takes priority over flush.
- cdb_valid = out_valid, cdb_data = out_data, cdb_tag = out_tag.
- Requesters drop or replace their entry in the cycle they see req_grant. The arbiter does not remember ungranted requests.

Test Plan:
1. Reset, then req_valid=4'b0001, op=AND, a=32'hF0F0_FFFF, b=32'h0FF0_00FF, tag=5 -> grant=0001 the same cycle. The next cycle has cdb_valid=1, cdb_data=32'h00F0_00FF, cdb_tag=5, and rr_ptr=1.
2. req_valid=4'b1111 held for 4 cycles, cdb_ready=1 -> grants 0001, 0010, 0100, 1000 in order. One result per cycle with tags matching each requester.
3. cdb_ready=0 with out_valid=1, req_valid=4'b0100 -> req_grant=0 and cdb_data/cdb_tag stable for 3 cycles. On the cycle cdb_ready rises, grant=0100 and the register updates next edge with cdb_valid continuous.
4. rr_ptr=3 with req_valid=4'b1001 -> grant=1000, then rr_ptr wraps to 0. The following cycle, req_valid=4'b1001 -> grant=0001.
5. out_valid=1, flush=1, cdb_ready=1, req_valid=4'b0010 -> no grant and cdb_valid=0 next cycle. rr_ptr is unchanged.
6. Assert reset while out_valid=1 and req_valid=4'b1111 -> req_grant=0 that cycle. Next cycle cdb_valid=0, cdb_data=0, cdb_tag=0, and after release the first grant goes to requester 0.
